// File: rtl/box_sprite_drawer_if.sv
// Sprite drawer bus: game-side start request plus VGA adapter write port.
// Master requests a draw and consumes pixels; slave is the drawer.
interface box_sprite_drawer_if;
  logic       start;
  logic       erase;
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic [2:0] bg_colour;
  logic       busy;
  logic       done;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  modport master (
    output start, erase, org_x, org_y, bg_colour,
    input  busy, done, plot, x, y, colour
  );

  modport slave (
    input  start, erase, org_x, org_y, bg_colour,
    output busy, done, plot, x, y, colour
  );
endinterface

// File: rtl/box_sprite_drawer.sv
// Box sprite drawer: plots a table of filled rectangles one pixel per clock,
// relative to a latched origin, clipped to the screen, with an erase mode.
module box_sprite_drawer #(
  parameter int NUM_BOXES = 7,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter logic [NUM_BOXES*33-1:0] BOX_TABLE = '0
) (
  input logic          clock,
  input logic          resetn,
  box_sprite_drawer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_BOXES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  col;
  logic [6:0]  row;
  logic        ers;
  logic [7:0]  ox;
  logic [6:0]  oy;
  logic [2:0]  bg;

  logic [32:0] ent;
  logic [7:0]  dx, w;
  logic [6:0]  dy, h;
  logic [2:0]  bc, pc;
  logic [7:0]  nc;
  logic [6:0]  nr;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        on, empty, last_px, last_box;

  // Current entry decode and address of the pixel shown next cycle
  always_comb begin
    ent = '0;
    for (int i = 0; i < NUM_BOXES; i++)
      if (idx == 4'(i))
        ent = BOX_TABLE[33*i +: 33];
    {dx, dy, w, h, bc} = ent;
    empty    = (w == 8'd0) || (h == 7'd0);
    last_px  = (col == w - 8'd1) && (row == h - 7'd1);
    last_box = (idx == LAST);
    nc = 8'd0;
    nr = 7'd0;
    if (state == DRAW) begin
      if (col == w - 8'd1) begin
        nc = 8'd0;
        nr = row + 7'd1;
      end else begin
        nc = col + 8'd1;
        nr = row;
      end
    end
    px = {1'b0, ox} + {1'b0, dx} + {1'b0, nc};
    py = {1'b0, oy} + {1'b0, dy} + {1'b0, nr};
    on = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    pc = ers ? bg : bc;
  end

  // Sequencer: walks boxes and pixels, registering the adapter outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= 4'd0;
      col        <= 8'd0;
      row        <= 7'd0;
      ers        <= 1'b0;
      ox         <= 8'd0;
      oy         <= 7'd0;
      bg         <= 3'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.plot   <= 1'b0;
      bus.x      <= 8'd0;
      bus.y      <= 7'd0;
      bus.colour <= 3'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ers      <= bus.erase;
            ox       <= bus.org_x;
            oy       <= bus.org_y;
            bg       <= bus.bg_colour;
            idx      <= 4'd0;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          col <= 8'd0;
          row <= 7'd0;
          if (empty) begin
            if (last_box) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            state      <= DRAW;
            bus.plot   <= on;
            bus.x      <= px[7:0];
            bus.y      <= py[6:0];
            bus.colour <= pc;
          end
        end
        DRAW: begin
          if (last_px) begin
            bus.plot   <= 1'b0;
            bus.x      <= 8'd0;
            bus.y      <= 7'd0;
            bus.colour <= 3'd0;
            if (last_box) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              idx   <= idx + 4'd1;
              state <= LOAD;
            end
          end else begin
            col        <= nc;
            row        <= nr;
            bus.plot   <= on;
            bus.x      <= px[7:0];
            bus.y      <= py[6:0];
            bus.colour <= pc;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_box_sprite_drawer.sv
// Bench for box_sprite_drawer: four sprite tables, pixel scoreboard,
// latency / busy / done checks, clipping, erase, skip and reset cases.
module tb_box_sprite_drawer;
  logic clock;
  logic resetn;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sel;

  localparam logic [32:0] TAB_A = {8'd0, 7'd0, 8'd2, 7'd3, 3'b011};
  localparam logic [32:0] TAB_C = {8'd0, 7'd0, 8'd10, 7'd2, 3'b101};
  localparam logic [98:0] TAB_M = {
    8'd2, 7'd0, 8'd1, 7'd1, 3'd6,
    8'd3, 7'd1, 8'd0, 7'd1, 3'd2,
    8'd0, 7'd0, 8'd1, 7'd1, 3'd1
  };
  localparam logic [230:0] TAB_K = {
    8'd0,  7'd5,  8'd1,  7'd1, 3'd2,
    8'd19, 7'd5,  8'd1,  7'd1, 3'd6,
    8'd14, 7'd10, 8'd4,  7'd3, 3'd0,
    8'd2,  7'd10, 8'd4,  7'd3, 3'd0,
    8'd7,  7'd1,  8'd6,  7'd2, 3'd3,
    8'd5,  7'd0,  8'd10, 7'd4, 3'd1,
    8'd0,  7'd4,  8'd20, 7'd6, 3'd4
  };

  box_sprite_drawer_if ba ();
  box_sprite_drawer_if bc ();
  box_sprite_drawer_if bm ();
  box_sprite_drawer_if bk ();

  box_sprite_drawer #(.NUM_BOXES(1), .BOX_TABLE(TAB_A)) u_a (
    .clock(clock), .resetn(resetn), .bus(ba));
  box_sprite_drawer #(.NUM_BOXES(1), .BOX_TABLE(TAB_C)) u_c (
    .clock(clock), .resetn(resetn), .bus(bc));
  box_sprite_drawer #(.NUM_BOXES(3), .BOX_TABLE(TAB_M)) u_m (
    .clock(clock), .resetn(resetn), .bus(bm));
  box_sprite_drawer #(.NUM_BOXES(7), .BOX_TABLE(TAB_K)) u_k (
    .clock(clock), .resetn(resetn), .bus(bk));

  logic [20:0] oa, oc, om, ok, m;
  assign oa = {ba.busy, ba.done, ba.plot, ba.x, ba.y, ba.colour};
  assign oc = {bc.busy, bc.done, bc.plot, bc.x, bc.y, bc.colour};
  assign om = {bm.busy, bm.done, bm.plot, bm.x, bm.y, bm.colour};
  assign ok = {bk.busy, bk.done, bk.plot, bk.x, bk.y, bk.colour};

  always_comb begin
    m = '0;
    case (sel)
      0: m = oa;
      1: m = oc;
      2: m = om;
      3: m = ok;
      default: m = '0;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int which, input bit er,
                           input int ox, input int oy, input int bg);
    case (which)
      0: begin ba.erase = er; ba.org_x = 8'(ox); ba.org_y = 7'(oy); ba.bg_colour = 3'(bg); end
      1: begin bc.erase = er; bc.org_x = 8'(ox); bc.org_y = 7'(oy); bc.bg_colour = 3'(bg); end
      2: begin bm.erase = er; bm.org_x = 8'(ox); bm.org_y = 7'(oy); bm.bg_colour = 3'(bg); end
      default: begin bk.erase = er; bk.org_x = 8'(ox); bk.org_y = 7'(oy); bk.bg_colour = 3'(bg); end
    endcase
  endtask

  task automatic set_start(input int which, input bit v);
    case (which)
      0: ba.start = v;
      1: bc.start = v;
      2: bm.start = v;
      default: bk.start = v;
    endcase
  endtask

  task automatic push_model(input logic [527:0] tab, input int n, input bit ers,
                            input int ox, input int oy, input int bg,
                            output int exp_busy, output int exp_plots);
    exp_busy  = n + 1;
    exp_plots = 0;
    for (int i = 0; i < n; i++) begin
      logic [32:0] e;
      int dx, dy, w, h, c;
      e  = tab[33*i +: 33];
      dx = int'(e[32:25]);
      dy = int'(e[24:18]);
      w  = int'(e[17:10]);
      h  = int'(e[9:3]);
      c  = int'(e[2:0]);
      exp_busy += w * h;
      for (int r = 0; r < h; r++) begin
        for (int cc = 0; cc < w; cc++) begin
          int px, py;
          px = (ox + dx + cc) % 512;
          py = (oy + dy + r) % 256;
          if (px < 160 && py < 120) begin
            q.push_back('{px, py, ers ? bg : c});
            exp_plots++;
          end
        end
      end
    end
  endtask

  task automatic run(input int which, input logic [527:0] tab, input int n,
                     input bit ers, input int ox, input int oy, input int bg,
                     input int abort_t, input int mid_t, input int exp_first,
                     input string tag);
    int   exp_busy, exp_plots, limit;
    int   busy_n, done_n, done_t, plots, first, idle_bad;
    pix_t p;
    sel = which;
    q.delete();
    push_model(tab, n, ers, ox, oy, bg, exp_busy, exp_plots);
    busy_n = 0; done_n = 0; done_t = -1;
    plots = 0; first = -1; idle_bad = 0;
    limit = exp_busy + 10;
    drive_req(which, ers, ox, oy, bg);
    set_start(which, 1'b1);
    for (int t = 1; t <= limit; t++) begin
      @(negedge clock);
      if (t == 1) set_start(which, 1'b0);
      if (t == mid_t) set_start(which, 1'b1);
      if (t == mid_t + 1) set_start(which, 1'b0);
      if (t == abort_t) begin
        resetn = 1'b0;
        @(negedge clock);
        check({tag, "_rst_busy"}, int'(m[20]), 0);
        check({tag, "_rst_done"}, int'(m[19]), 0);
        check({tag, "_rst_plot"}, int'(m[18]), 0);
        resetn = 1'b1;
        q.delete();
        return;
      end
      if (m[20]) busy_n++;
      if (m[19]) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      if (!m[20] && m[18:0] != 19'd0) idle_bad++;
      if (m[18]) begin
        plots++;
        if (first < 0) first = t;
        if (q.size() == 0) begin
          check({tag, "_extra_plot"}, 1, 0);
        end else begin
          p = q.pop_front();
          check({tag, "_x"}, int'(m[17:10]), p.x);
          check({tag, "_y"}, int'(m[9:3]), p.y);
          check({tag, "_colour"}, int'(m[2:0]), p.c);
        end
      end
    end
    check({tag, "_busy_len"}, busy_n, exp_busy);
    check({tag, "_done_cnt"}, done_n, 1);
    check({tag, "_done_at"}, done_t, exp_busy);
    check({tag, "_plots"}, plots, exp_plots);
    check({tag, "_left"}, q.size(), 0);
    check({tag, "_idle_out"}, idle_bad, 0);
    if (exp_first >= 0) check({tag, "_first"}, first, exp_first);
  endtask

  initial begin
    resetn = 1'b0;
    sel = 0;
    for (int k = 0; k < 4; k++) begin
      set_start(k, 1'b0);
      drive_req(k, 1'b0, 0, 0, 0);
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      check("reset_busy", int'(m[20]), 0);
      check("reset_done", int'(m[19]), 0);
      check("reset_plot", int'(m[18]), 0);
      check("reset_xyc", int'(m[17:0]), 0);
    end
    resetn = 1'b1;
    @(negedge clock);

    run(0, 528'(TAB_A), 1, 1'b0, 10, 20, 0, -1, -1, 2, "t1");
    run(0, 528'(TAB_A), 1, 1'b1, 10, 20, 0, -1, -1, 2, "t3");
    run(0, 528'(TAB_A), 1, 1'b1, 10, 20, 5, -1, -1, 2, "t3b");
    run(1, 528'(TAB_C), 1, 1'b0, 155, 119, 0, -1, -1, 2, "t4");
    run(2, 528'(TAB_M), 3, 1'b0, 40, 40, 0, -1, 3, 2, "t5");
    run(3, 528'(TAB_K), 7, 1'b0, 80, 35, 0, -1, -1, 2, "t2");
    run(3, 528'(TAB_K), 7, 1'b0, 80, 35, 0, 50, -1, -1, "t6a");
    run(3, 528'(TAB_K), 7, 1'b1, 70, 30, 6, -1, -1, 2, "t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
